// File: rtl/vco_freq_ctrl.sv
// VCO frequency-lock controller: SAR search of the VCO control word against a target
// edge count per gate window, followed by +/-1 LSB tracking with a lock indicator.
module vco_freq_ctrl #(
    parameter int unsigned RESOLUTION_BITS = 32,
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned SETTLE_CYCLES   = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [CNT_WIDTH-1:0]       target_count_i,
    input  logic [CNT_WIDTH-1:0]       tol_i,
    input  logic [CNT_WIDTH-1:0]       window_i,
    input  logic                       vco_clk_i,
    output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
    output logic                       busy_o,
    output logic                       locked_o,
    output logic [CNT_WIDTH-1:0]       meas_count_o,
    output logic                       meas_valid_o
);

    localparam int unsigned IdxW = (RESOLUTION_BITS > 1) ? $clog2(RESOLUTION_BITS) : 1;
    localparam logic [IdxW-1:0] IdxTop = IdxW'(RESOLUTION_BITS - 1);
    localparam logic [31:0] SettleLast = SETTLE_CYCLES - 1;
    localparam bit SkipSettle = (SETTLE_CYCLES == 0);

    typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StEval} state_e;

    state_e                     state_q, state_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       track_q, track_d;
    logic [RESOLUTION_BITS-1:0] ctrl_q, ctrl_d;
    logic                       locked_q, locked_d;
    logic [CNT_WIDTH-1:0]       meas_count_q, meas_count_d;
    logic                       meas_valid_q, meas_valid_d;
    logic [CNT_WIDTH-1:0]       tgt_q, tgt_d;
    logic [CNT_WIDTH-1:0]       tol_q, tol_d;
    logic [CNT_WIDTH-1:0]       win_m1_q, win_m1_d;
    logic [31:0]                timer_q, timer_d;
    logic [CNT_WIDTH-1:0]       edge_cnt_q, edge_cnt_d;
    logic                       sync1_q, sync2_q, sync3_q, edge_q;

    logic [CNT_WIDTH:0]         tgt_hi, tgt_lo;
    logic [CNT_WIDTH-1:0]       cnt_final;
    logic [IdxW-1:0]            idx_dec;
    state_e                     run_state;

    // Synchronise the VCO output and register a one-cycle pulse per rising edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= vco_clk_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            track_q      <= 1'b0;
            ctrl_q       <= '0;
            locked_q     <= 1'b0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            tgt_q        <= '0;
            tol_q        <= '0;
            win_m1_q     <= '0;
            timer_q      <= '0;
            edge_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            track_q      <= track_d;
            ctrl_q       <= ctrl_d;
            locked_q     <= locked_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            tgt_q        <= tgt_d;
            tol_q        <= tol_d;
            win_m1_q     <= win_m1_d;
            timer_q      <= timer_d;
            edge_cnt_q   <= edge_cnt_d;
        end
    end

    // Next-state logic: sequencing, SAR bit decisions and tracking steps.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        track_d      = track_q;
        ctrl_d       = ctrl_q;
        locked_d     = locked_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        tgt_d        = tgt_q;
        tol_d        = tol_q;
        win_m1_d     = win_m1_q;
        timer_d      = timer_q;
        edge_cnt_d   = edge_cnt_q;

        // target+tol is never clamped; target-tol floors at zero.
        tgt_hi    = {1'b0, tgt_q} + {1'b0, tol_q};
        tgt_lo    = (tgt_q >= tol_q) ? {1'b0, tgt_q - tol_q} : '0;
        // Count including an edge arriving on the final window cycle, saturating.
        cnt_final = edge_cnt_q + CNT_WIDTH'(edge_q && (edge_cnt_q != '1));
        idx_dec   = idx_q - IdxW'(1);
        run_state = SkipSettle ? StMeasure : StSettle;

        if (abort_i) begin
            state_d  = StIdle;
            track_d  = 1'b0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d    = run_state;
                        idx_d      = IdxTop;
                        track_d    = 1'b0;
                        locked_d   = 1'b0;
                        ctrl_d     = '0;
                        ctrl_d[RESOLUTION_BITS-1] = 1'b1;
                        tgt_d      = target_count_i;
                        tol_d      = tol_i;
                        win_m1_d   = (window_i == '0) ? '0 : window_i - CNT_WIDTH'(1);
                        timer_d    = '0;
                        edge_cnt_d = '0;
                    end
                end
                StSettle: begin
                    timer_d = timer_q + 32'd1;
                    if (timer_q == SettleLast) begin
                        state_d    = StMeasure;
                        timer_d    = '0;
                        edge_cnt_d = '0;
                    end
                end
                StMeasure: begin
                    timer_d    = timer_q + 32'd1;
                    edge_cnt_d = cnt_final;
                    if (timer_q == 32'(win_m1_q)) begin
                        state_d      = StEval;
                        timer_d      = '0;
                        meas_count_d = cnt_final;
                        meas_valid_d = 1'b1;
                    end
                end
                StEval: begin
                    if (!track_q) begin
                        if (meas_count_q > tgt_q) begin
                            ctrl_d[idx_q] = 1'b0;
                        end
                        if (idx_q != '0) begin
                            idx_d          = idx_dec;
                            ctrl_d[idx_dec] = 1'b1;
                        end else begin
                            track_d = 1'b1;
                        end
                    end else if ({1'b0, meas_count_q} > tgt_hi) begin
                        locked_d = 1'b0;
                        if (ctrl_q != '0) ctrl_d = ctrl_q - RESOLUTION_BITS'(1);
                    end else if ({1'b0, meas_count_q} < tgt_lo) begin
                        locked_d = 1'b0;
                        if (ctrl_q != '1) ctrl_d = ctrl_q + RESOLUTION_BITS'(1);
                    end else begin
                        locked_d = 1'b1;
                    end
                    state_d    = run_state;
                    timer_d    = '0;
                    edge_cnt_d = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign voltage_ctrl_o = ctrl_q;
    assign busy_o         = (state_q != StIdle);
    assign locked_o       = locked_q;
    assign meas_count_o   = meas_count_q;
    assign meas_valid_o   = meas_valid_q;

endmodule
